// File: rtl/version_pkg.sv
// ============================================================================
// version_pkg : build-identity constants plus frame layout for version_reporter
// Revision    : 1.0
// ============================================================================
`default_nettype none

package version_pkg;

    // Build identity; date/time fields are BCD so they read naturally on a terminal
    localparam logic [7:0]  C_VER_MAJOR    = 8'd0;
    localparam logic [7:0]  C_VER_MINOR    = 8'd0;
    localparam logic [7:0]  C_VER_PATCH    = 8'd0;
    localparam logic [7:0]  C_VER_BUILD    = 8'd59;
    localparam logic [15:0] C_BUILD_YEAR   = 16'h2025;
    localparam logic [7:0]  C_BUILD_MONTH  = 8'h11;
    localparam logic [7:0]  C_BUILD_DAY    = 8'h07;
    localparam logic [7:0]  C_BUILD_HOUR   = 8'h16;
    localparam logic [7:0]  C_BUILD_MINUTE = 8'h19;
    localparam logic [7:0]  C_BUILD_SECOND = 8'h55;

    localparam int C_VREP_LEN_BASE  = 12;
    localparam int C_VREP_LEN_CKSUM = 13;

    localparam logic [3:0] C_VREP_IDX_HDR    = 4'd0;
    localparam logic [3:0] C_VREP_IDX_MAJOR  = 4'd1;
    localparam logic [3:0] C_VREP_IDX_MINOR  = 4'd2;
    localparam logic [3:0] C_VREP_IDX_PATCH  = 4'd3;
    localparam logic [3:0] C_VREP_IDX_BUILD  = 4'd4;
    localparam logic [3:0] C_VREP_IDX_YEARH  = 4'd5;
    localparam logic [3:0] C_VREP_IDX_YEARL  = 4'd6;
    localparam logic [3:0] C_VREP_IDX_MONTH  = 4'd7;
    localparam logic [3:0] C_VREP_IDX_DAY    = 4'd8;
    localparam logic [3:0] C_VREP_IDX_HOUR   = 4'd9;
    localparam logic [3:0] C_VREP_IDX_MINUTE = 4'd10;
    localparam logic [3:0] C_VREP_IDX_SECOND = 4'd11;
    localparam logic [3:0] C_VREP_IDX_CKSUM  = 4'd12;

    typedef enum logic [1:0] {
        VREP_IDLE  = 2'd0,
        VREP_SEND  = 2'd1,
        VREP_CKSUM = 2'd2,
        VREP_DONE  = 2'd3
    } vrep_state_t;

    function automatic logic [7:0] vrep_payload_byte(input logic [3:0] idx,
                                                     input logic [7:0] hdr);
        case (idx)
            C_VREP_IDX_HDR:    return hdr;
            C_VREP_IDX_MAJOR:  return C_VER_MAJOR;
            C_VREP_IDX_MINOR:  return C_VER_MINOR;
            C_VREP_IDX_PATCH:  return C_VER_PATCH;
            C_VREP_IDX_BUILD:  return C_VER_BUILD;
            C_VREP_IDX_YEARH:  return C_BUILD_YEAR[15:8];
            C_VREP_IDX_YEARL:  return C_BUILD_YEAR[7:0];
            C_VREP_IDX_MONTH:  return C_BUILD_MONTH;
            C_VREP_IDX_DAY:    return C_BUILD_DAY;
            C_VREP_IDX_HOUR:   return C_BUILD_HOUR;
            C_VREP_IDX_MINUTE: return C_BUILD_MINUTE;
            C_VREP_IDX_SECOND: return C_BUILD_SECOND;
            default:           return 8'h00;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/version_beacon_timer.sv
// ============================================================================
// version_beacon_timer : free-running 0..PERIOD-1 counter, one-cycle tick on wrap
// Revision             : 1.0
// ============================================================================
`default_nettype none

module version_beacon_timer #(
    parameter int PERIOD = 100
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int         C_W    = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [C_W-1:0] C_LAST = C_W'(PERIOD - 1);

    logic [C_W-1:0] cnt_q;
    logic [C_W-1:0] cnt_d;

    assign tick_o = (cnt_q == C_LAST);
    assign cnt_d  = tick_o ? '0 : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/version_reporter.sv
// ============================================================================
// version_reporter : streams the build-identity frame on a valid/ready byte link
// Config macro     : VERSION_REPORTER_CKSUM_EN appends an XOR checksum byte
// Revision         : 1.0
// ============================================================================
`default_nettype none

module version_reporter
    import version_pkg::*;
#(
    parameter int         BEACON_CYCLES = 0,
    parameter logic [7:0] FRAME_HDR     = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_i,
    output logic [7:0] tx_data_o,
    output logic       tx_valid_o,
    input  logic       tx_ready_i,
    output logic       busy_o,
    output logic       frame_done_o
);

    logic        beacon_tick;

    generate
        if (BEACON_CYCLES > 0) begin : g_beacon
            version_beacon_timer #(
                .PERIOD (BEACON_CYCLES)
            ) u_beacon (
                .clk    (clk),
                .rst_n  (rst_n),
                .tick_o (beacon_tick)
            );
        end else begin : g_no_beacon
            assign beacon_tick = 1'b0;
        end
    endgenerate

    vrep_state_t state_q, state_d;
    logic [3:0]  idx_q, idx_d;
    logic        pend_q, pend_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
`ifdef VERSION_REPORTER_CKSUM_EN
    logic [7:0]  cksum_q, cksum_d;
`endif

    logic        accept;
    logic        event_in;
    logic [3:0]  idx_next;

    assign accept   = tx_valid_q & tx_ready_i;
    assign event_in = req_i | beacon_tick;
    assign idx_next = idx_q + 4'd1;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        pend_d     = pend_q | event_in;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        done_d     = 1'b0;
`ifdef VERSION_REPORTER_CKSUM_EN
        cksum_d    = cksum_q;
`endif
        case (state_q)
            VREP_IDLE: begin
                if (pend_q) begin
                    // An event landing on the entry cycle is a new request, not part of this frame
                    state_d    = VREP_SEND;
                    pend_d     = event_in;
                    idx_d      = C_VREP_IDX_HDR;
                    tx_data_d  = FRAME_HDR;
                    tx_valid_d = 1'b1;
`ifdef VERSION_REPORTER_CKSUM_EN
                    cksum_d    = 8'h00;
`endif
                end
            end
            VREP_SEND: begin
                if (accept) begin
`ifdef VERSION_REPORTER_CKSUM_EN
                    cksum_d = cksum_q ^ tx_data_q;
`endif
                    if (idx_q == C_VREP_IDX_SECOND) begin
`ifdef VERSION_REPORTER_CKSUM_EN
                        state_d   = VREP_CKSUM;
                        idx_d     = C_VREP_IDX_CKSUM;
                        tx_data_d = cksum_q ^ tx_data_q;
`else
                        state_d    = VREP_DONE;
                        tx_valid_d = 1'b0;
                        done_d     = 1'b1;
`endif
                    end else begin
                        idx_d     = idx_next;
                        tx_data_d = vrep_payload_byte(idx_next, FRAME_HDR);
                    end
                end
            end
`ifdef VERSION_REPORTER_CKSUM_EN
            VREP_CKSUM: begin
                if (accept) begin
                    state_d    = VREP_DONE;
                    tx_valid_d = 1'b0;
                    done_d     = 1'b1;
                end
            end
`endif
            VREP_DONE: begin
                state_d = VREP_IDLE;
                idx_d   = C_VREP_IDX_HDR;
            end
            default: begin
                state_d    = VREP_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != VREP_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= VREP_IDLE;
            idx_q      <= 4'd0;
            pend_q     <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef VERSION_REPORTER_CKSUM_EN
            cksum_q    <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            pend_q     <= pend_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef VERSION_REPORTER_CKSUM_EN
            cksum_q    <= cksum_d;
`endif
        end
    end

    assign tx_data_o    = tx_data_q;
    assign tx_valid_o   = tx_valid_q;
    assign busy_o       = busy_q;
    assign frame_done_o = done_q;

endmodule

`default_nettype wire

// File: doc/version_reporter.md
# version_reporter

Sequencer that reads the build-identity constants from `version_pkg` and emits them as a fixed byte frame on a valid/ready byte stream. The frame carries version, build number and build timestamp. A frame is sent on request, or periodically as a beacon. It sits between the host-command decoder and the shared UART TX byte path.

## Interface
Parameters:
- `BEACON_CYCLES`, default 0: beacon period in `clk` cycles; 0 disables the beacon.
- `FRAME_HDR`, default 8'hA5: first byte of every frame.

Ports:
- `clk` in 1: single clock domain.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_i` in 1: single-cycle report request.
- `tx_data_o` out 8: frame byte.
- `tx_valid_o` out 1: `tx_data_o` is valid.
- `tx_ready_i` in 1: sink accepts the byte when `tx_valid_o` and `tx_ready_i` are both 1 at a rising edge.
- `busy_o` out 1: a frame is in progress.
- `frame_done_o` out 1: one-cycle pulse after the last byte is accepted.

## Operation
- Frame byte order, index 0..11:
  - 0 HDR, 1 MAJOR, 2 MINOR, 3 PATCH, 4 BUILD.
  - 5 YEAR[15:8], 6 YEAR[7:0].
  - 7 MONTH, 8 DAY, 9 HOUR, 10 MINUTE, 11 SECOND.
  - Index 12 is CKSUM only when checksum is compiled in.
- CKSUM = XOR of bytes 0..11, accumulated in an 8-bit register as bytes are accepted.
- FSM states:
  - IDLE → SEND when `pend` is 1.
  - SEND: index advances on each accepted byte. When the last payload byte is accepted → CKSUM if compiled in, else → DONE.
  - CKSUM: → DONE when the checksum byte is accepted.
  - DONE: lasts one cycle, drives `frame_done_o`=1, → IDLE.
- `pend` flag:
  - Set by `req_i` or beacon terminal count in any state.
  - Cleared on entry to SEND.
  - Requests coalesce: any number of events during a frame yield exactly one further frame.
- Beacon counter:
  - Free-running, 0..BEACON_CYCLES-1, wraps to 0.
  - Raises a beacon event when it wraps.
  - Counts regardless of FSM state.
  - Not instantiated when BEACON_CYCLES=0.
- `req_i` and a beacon event in the same cycle: a single `pend` set, one frame.
- Handshake:
  - Once `tx_valid_o` rises, `tx_valid_o` and `tx_data_o` hold stable until accepted.
  - `tx_valid_o` never drops mid-frame.
  - `tx_ready_i` may toggle arbitrarily.
- `busy_o` is 1 in SEND, CKSUM and DONE.

## Timing
- Reset values, all asynchronous on `rst_n`=0:
  - `tx_data_o`=0, `tx_valid_o`=0, `busy_o`=0, `frame_done_o`=0.
  - `pend`=0, index=0, cksum=0, beacon counter=0.
- Reset mid-frame aborts the frame; no partial resume after reset.
- All outputs are registered.
- Request latency:
  - `req_i` high at edge N, FSM IDLE → `tx_valid_o`=1 with HDR after edge N+1.
  - Takes one cycle to set `pend`, one cycle to enter SEND.
- With `tx_ready_i` held at 1, one byte per cycle:
  - Frame occupies 12 cycles, or 13 with checksum.
  - Then one DONE cycle with `tx_valid_o`=0.
- Back-to-back frames from `pend`: at least 2 cycles with `tx_valid_o`=0 between frames (DONE, then IDLE).
- Beacon terminal count while busy: frame follows the current one per the gap above.

## Configuration
- Macro `VERSION_REPORTER_CKSUM_EN`.
- Defined:
  - 13-byte frame; byte 12 is CKSUM.
  - CKSUM state and XOR accumulator present.
- Undefined:
  - 12-byte frame; SEND → DONE directly.
  - No accumulator logic synthesized.

## Structure
- Shared package: add to `version_pkg`:
  - Frame length localparams `C_VREP_LEN_BASE`=12 and `C_VREP_LEN_CKSUM`=13.
  - Byte-index localparams.
  - FSM state enum typedef `vrep_state_t`.
- Sub-module `version_beacon_timer`:
  - Parameterized period; outputs a one-cycle tick on wrap.
  - Instantiated under a generate if BEACON_CYCLES>0.
- Byte mux is combinational on index, then registered into `tx_data_o`.

## Test plan
Expected bytes are computed from `version_pkg` at bench compile time. Example values are for 0.0.0.59, 2025-11-07 16:19:55.

- Single `req_i` pulse, `tx_ready_i`=1:
  - Bytes A5,00,00,00,3B,20,25,11,07,16,19,55, then D7 if CKSUM_EN.
  - `frame_done_o` one cycle after the last byte; `tx_valid_o` first high 2 edges after `req_i`.
- Random `tx_ready_i` (50%) backpressure:
  - Same byte sequence.
  - `tx_data_o` and `tx_valid_o` stable while `tx_valid_o`=1 and `tx_ready_i`=0.
- Three `req_i` pulses during one frame → exactly two frames total, with the inter-frame gap satisfied.
- BEACON_CYCLES=100, no `req_i` for 1000 cycles → 10 frames. `req_i` coincident with a beacon tick → one frame.
- `rst_n` asserted at frame byte 6:
  - All outputs 0 immediately.
  - After release, no output until a new `req_i`; that frame starts at HDR.
- Build without the macro: 12 bytes, SEND → DONE, no CKSUM byte emitted.
